// File: rtl/util_trafic_pkg.sv
// Shared definitions for the traffic utilities: skid-slice state encoding and
// the tdata bit mask used when a beat is corrupted.
package util_trafic_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    localparam logic [63:0] INJECT_MASK = 64'h1;

endpackage

// File: rtl/util_trafic_injector_if.sv
// AXI-Stream bundle used on both sides of the traffic injector.
interface util_trafic_injector_if #(
    parameter int unsigned TBYTE_NUM  = 8,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 2
) ();

    logic                    tvalid;
    logic                    tready;
    logic [TBYTE_NUM*8-1:0]  tdata;
    logic [TBYTE_NUM-1:0]    tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;

    modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, output tready);

endinterface

// File: rtl/util_axis_skid.sv
// Two-entry skid register slice: registered valid/ready, one beat per cycle,
// no combinational path between the two handshake sides.
module util_axis_skid
    import util_trafic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic             in_acc;
    logic             out_acc;

    assign in_acc  = s_valid & s_ready_q;
    assign out_acc = m_valid_q & m_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (in_acc) begin
                    out_d   = s_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (in_acc && out_acc) begin
                    out_d = s_data;
                end else if (in_acc) begin
                    skid_d  = s_data;
                    state_d = SKID_FULL;
                end else if (out_acc) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // ready is low here, so only the drain side can move
                if (out_acc) begin
                    out_d   = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        m_valid_d = (state_d != SKID_EMPTY);
        s_ready_d = (state_d != SKID_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SKID_EMPTY;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
        out_q  <= out_d;
        skid_q <= skid_d;
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = out_q;

endmodule

// File: rtl/util_trafic_injector.sv
// AXI-Stream pass-through that flips tdata bit 0 on selected beats, either
// periodically or on demand, and counts the corrupted beats.
module util_trafic_injector
    import util_trafic_pkg::*;
#(
    parameter int unsigned TBYTE_NUM  = 8,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 2,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [15:0]          inject_period,
    input  logic                 inject_once,
    output logic [CNT_WIDTH-1:0] inject_cnt,
    util_trafic_injector_if.slave  s_axis,
    util_trafic_injector_if.master m_axis
);

    localparam int unsigned DATA_W = TBYTE_NUM * 8;
    localparam int unsigned PAY_W  = DATA_W + TBYTE_NUM + 1 + ID_WIDTH + DEST_WIDTH;
    localparam logic [DATA_W-1:0] MASK = DATA_W'(INJECT_MASK);

    logic [15:0]          beat_q, beat_d;
    logic [15:0]          period_q, period_d;
    logic                 pending_q, pending_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 s_ready;
    logic                 in_acc;
    logic                 period_hit;
    logic                 corrupt;
    logic [DATA_W-1:0]    tdata_c;
    logic [PAY_W-1:0]     in_pay;
    logic [PAY_W-1:0]     out_pay;

    assign in_acc = s_axis.tvalid & s_ready;

    always_comb begin
        period_d   = inject_period;
        beat_d     = beat_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        period_hit = (inject_period != '0) && (beat_q == inject_period - 16'd1);
        corrupt    = en && in_acc && (period_hit || pending_q || inject_once);

        // a new period restarts the count; with en low the count is frozen
        if (inject_period != period_q) begin
            beat_d = '0;
        end else if (en && in_acc) begin
            beat_d = period_hit ? '0 : beat_q + 16'd1;
        end

        if (en && in_acc) begin
            pending_d = 1'b0;
        end else if (inject_once) begin
            pending_d = 1'b1;
        end

        if (corrupt && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        tdata_c = corrupt ? (s_axis.tdata ^ MASK) : s_axis.tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q    <= '0;
            period_q  <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            beat_q    <= beat_d;
            period_q  <= period_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_pay = {tdata_c, s_axis.tkeep, s_axis.tlast, s_axis.tid, s_axis.tdest};

    util_axis_skid #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_axis.tvalid),
        .s_ready (s_ready),
        .s_data  (in_pay),
        .m_valid (m_axis.tvalid),
        .m_ready (m_axis.tready),
        .m_data  (out_pay)
    );

    assign s_axis.tready = s_ready;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest} = out_pay;
    assign inject_cnt = cnt_q;

endmodule

// File: tb/tb_util_trafic_injector.sv
// Scoreboard bench for util_trafic_injector: stimulus pushes expected beats,
// an independent monitor pops and compares them as they leave the DUT.
module tb_util_trafic_injector;

    localparam int unsigned TBN = 8;
    localparam int unsigned IDW = 1;
    localparam int unsigned DW  = 2;
    localparam int unsigned CW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [15:0]   inject_period = '0;
    logic          inject_once = 1'b0;
    logic [CW-1:0] inject_cnt;

    util_trafic_injector_if #(.TBYTE_NUM(TBN), .ID_WIDTH(IDW), .DEST_WIDTH(DW)) s_if ();
    util_trafic_injector_if #(.TBYTE_NUM(TBN), .ID_WIDTH(IDW), .DEST_WIDTH(DW)) m_if ();

    util_trafic_injector #(
        .TBYTE_NUM  (TBN),
        .ID_WIDTH   (IDW),
        .DEST_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .inject_period (inject_period),
        .inject_once   (inject_once),
        .inject_cnt    (inject_cnt),
        .s_axis        (s_if),
        .m_axis        (m_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]    d;
        logic [7:0]     k;
        logic           l;
        logic [IDW-1:0] id;
        logic [DW-1:0]  dst;
        int             cyc;
        bit             lat;
    } beat_t;

    beat_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          rst_prev = 1'b1;
    int            rdy_mode = 0;   // 0 stall, 1 always ready, 2 random 50%
    bit            lat_mode = 1'b0;

    // reference model state
    int            idx = 0;
    int            per = 0;
    bit            pend = 1'b0;
    logic [CW-1:0] exp_cnt = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                default: m_if.tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // monitor: occupancy tracked from observed handshakes, beats checked in order
    beat_t mon_e;
    int    occ = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                occ = 0;
            end else begin
                if (!rst_prev) begin
                    checks++;
                    if (s_if.tready !== (occ != 2)) begin
                        errors++;
                        $display("FAIL s_tready: got %b expected %b (occupancy %0d)", s_if.tready, (occ != 2), occ);
                    end
                end
                checks++;
                if (m_if.tvalid !== (occ != 0)) begin
                    errors++;
                    $display("FAIL m_tvalid: got %b expected %b (occupancy %0d)", m_if.tvalid, (occ != 0), occ);
                end
                if (m_if.tvalid && m_if.tready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL beat_extra: got tdata %h expected no beat", m_if.tdata);
                    end else begin
                        mon_e = sb.pop_front();
                        if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest} !==
                            {mon_e.d, mon_e.k, mon_e.l, mon_e.id, mon_e.dst}) begin
                            errors++;
                            $display("FAIL beat: got d=%h k=%h l=%b id=%h dst=%h expected d=%h k=%h l=%b id=%h dst=%h",
                                     m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest,
                                     mon_e.d, mon_e.k, mon_e.l, mon_e.id, mon_e.dst);
                        end
                        if (mon_e.lat) begin
                            checks++;
                            if (cyc != mon_e.cyc + 1) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles expected 1", cyc - mon_e.cyc);
                            end
                        end
                    end
                end
                if (s_if.tvalid && s_if.tready) occ = occ + 1;
                if (m_if.tvalid && m_if.tready) occ = occ - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock: decide acceptance before the edge and apply the reference rules
    task automatic step(output bit acc);
        beat_t e;
        bit    cor;
        @(negedge clk);
        acc = s_if.tvalid && s_if.tready && !rst;
        if (acc) begin
            if (en) idx++;
            cor = en && (((per != 0) && (idx % per == 0)) || pend || inject_once);
            e.d   = s_if.tdata ^ (cor ? 64'h1 : 64'h0);
            e.k   = s_if.tkeep;
            e.l   = s_if.tlast;
            e.id  = s_if.tid;
            e.dst = s_if.tdest;
            e.cyc = cyc;
            e.lat = lat_mode;
            sb.push_back(e);
            if (cor && (exp_cnt != '1)) exp_cnt = exp_cnt + 1;
        end
        if (acc && en) pend = 1'b0;
        else if (inject_once) pend = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit once);
        bit acc;
        s_if.tvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            inject_once = once && (i == 0);
            step(acc);
        end
        inject_once = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input bit once);
        bit acc = 1'b0;
        int n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = 8'($urandom);
        s_if.tlast  = 1'($urandom);
        s_if.tid    = IDW'($urandom);
        s_if.tdest  = DW'($urandom);
        while (!acc && n < 200) begin
            inject_once = once && (n == 0);
            step(acc);
            n++;
        end
        if (!acc) chk("send_timeout", 64'(n), 64'(0));
        s_if.tvalid = 1'b0;
        inject_once = 1'b0;
    endtask

    task automatic set_period(input int p);
        inject_period = 16'(p);
        per = p;
        idx = 0;
        idle(2, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 1;
        while (sb.size() != 0 && n < 100) begin
            idle(1, 1'b0);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        chk("inject_cnt", 64'(inject_cnt), 64'(exp_cnt));
    endtask

    logic [CW-1:0] base;
    bit            acc_dummy;

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tid    = '0;
        s_if.tdest  = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_if.tready), 64'(0));
        chk("rst_inject_cnt", 64'(inject_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(acc_dummy);
        chk("rel_s_tready", 64'(s_if.tready), 64'(1));

        // en=0 pass-through, back-to-back, 1-cycle latency
        rdy_mode = 1;
        idle(1, 1'b0);
        set_period(4);
        lat_mode = 1'b1;
        for (int i = 0; i < 100; i++) send_beat({$urandom, $urandom}, 1'b0);
        idle(1, 1'b0);
        lat_mode = 1'b0;
        drain();
        chk("en0_cnt", 64'(inject_cnt), 64'(0));

        // periodic injection, period 4
        en = 1'b1;
        set_period(0);
        set_period(4);
        base = inject_cnt;
        for (int i = 0; i < 16; i++) send_beat(64'h0, 1'b0);
        drain();
        chk("period4_cnt", 64'(inject_cnt - base), 64'(4));

        // single-shot injection armed before beat 3
        set_period(0);
        base = inject_cnt;
        send_beat(64'h0, 1'b0);
        send_beat(64'h0, 1'b0);
        idle(1, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(64'h0, 1'b0);
        drain();
        chk("once_cnt", 64'(inject_cnt - base), 64'(1));

        // pending survives en=0 and fires on the first enabled beat
        en = 1'b0;
        base = inject_cnt;
        idle(1, 1'b1);
        for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom}, 1'b0);
        en = 1'b1;
        send_beat(64'h0, 1'b0);
        send_beat(64'h0, 1'b0);
        drain();
        chk("pending_cnt", 64'(inject_cnt - base), 64'(1));

        // period 1 plus coinciding once: one corruption per beat
        set_period(1);
        base = inject_cnt;
        send_beat(64'h0, 1'b1);
        for (int i = 0; i < 9; i++) send_beat(64'h0, 1'b0);
        drain();
        chk("period1_cnt", 64'(inject_cnt - base), 64'(10));

        // random backpressure, random enable and once pulses
        set_period(int'($urandom_range(2, 7)));
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) idle(1, ($urandom_range(0, 9) == 0));
            send_beat({$urandom, $urandom}, ($urandom_range(0, 9) == 0));
        end
        drain();

        // reset with the slice full discards both beats
        rdy_mode = 0;
        idle(1, 1'b0);
        send_beat({$urandom, $urandom}, 1'b0);
        send_beat({$urandom, $urandom}, 1'b0);
        chk("full_s_tready", 64'(s_if.tready), 64'(0));
        rst = 1'b1;
        step(acc_dummy);
        rst = 1'b0;
        idx = 0;
        pend = 1'b0;
        exp_cnt = '0;
        chk("rstfull_m_tvalid", 64'(m_if.tvalid), 64'(0));
        chk("rstfull_inject_cnt", 64'(inject_cnt), 64'(0));
        chk("rstfull_s_tready", 64'(s_if.tready), 64'(0));
        step(acc_dummy);
        chk("rstfull_rel_tready", 64'(s_if.tready), 64'(1));

        // traffic resumes cleanly after reset
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) send_beat({$urandom, $urandom}, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/util_trafic_injector.md
UTIL_TRAFIC_INJECTOR -- requirements
Module: util_trafic_injector

Interface
REQ-001 SHALL have parameter TBYTE_NUM, default 8: AXIS data width in bytes.
REQ-002 SHALL have parameter ID_WIDTH, default 1: tid width.
REQ-003 SHALL have parameter DEST_WIDTH, default 2: tdest width.
REQ-004 SHALL have parameter CNT_WIDTH, default 32: width of inject_cnt.
REQ-005 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-007 SHALL have port en  in  1: master enable for injection; the datapath always passes traffic.
REQ-008 SHALL have port inject_period  in  16: inject on every Nth accepted beat; 0 disables periodic injection.
REQ-009 SHALL have port inject_once  in  1: single-cycle pulse arming one injection.
REQ-010 SHALL have port inject_cnt  out  CNT_WIDTH: count of corrupted beats.
REQ-011 SHALL have ports s_axis_tvalid/tready/tdata/tkeep/tlast/tid/tdest  in (tready out)  1/1/TBYTE_NUM*8/TBYTE_NUM/1/ID_WIDTH/DEST_WIDTH: upstream side, fed by util_trafic_monitor m_axis.
REQ-012 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast/tid/tdest, with the same widths and mirrored directions: downstream side, feeding util_trafic_receiver s_axis.

Function
REQ-013 Datapath SHALL be a 2-entry skid register slice: 1-cycle latency, 1 beat/cycle sustained, no combinational path from s_* to m_* or from m_axis_tready to s_axis_tready.
REQ-014 Slice states SHALL be EMPTY (no valid data), ONE (output register valid), FULL (output and skid valid); s_axis_tready = (state != FULL), registered.
REQ-015 Transitions: EMPTY->ONE on input accept; ONE->FULL on accept with m stalled; ONE->EMPTY on output accept with no input; FULL->ONE on output accept; all other cases hold.
REQ-016 Beat order, tkeep, tlast, tid and tdest SHALL be preserved unmodified.
REQ-017 Beat counter SHALL increment on each s_axis accept and wrap to 0 when it reaches inject_period-1; that beat is the period beat.
REQ-018 inject_once SHALL set a pending flag; the flag clears on the next accepted beat, which is then corrupted; pulses while pending are absorbed.
REQ-019 A beat SHALL be corrupted when en=1 and (period beat with inject_period!=0, or pending set, or inject_once high in the same accept cycle); corruption = tdata bit 0 inverted, applied at capture.
REQ-020 Period and once coinciding on one beat SHALL corrupt that beat once and increment inject_cnt once.
REQ-021 inject_cnt SHALL increment per corrupted beat and saturate at all-ones.
REQ-022 A change of inject_period SHALL reset the beat counter to 0 the following cycle.
REQ-023 With en=0, beats SHALL pass bit-exact, the beat counter SHALL hold, and pending SHALL be retained.

Reset
REQ-024 On rst: state EMPTY, m_axis_tvalid=0, s_axis_tready=0 (1 from the first cycle after release), beat counter 0, pending 0, inject_cnt 0.
REQ-025 rst mid-packet SHALL discard buffered beats without emitting partial output; data registers need not reset.

Structure
REQ-026 Shared package util_trafic_pkg SHALL hold the slice state encoding and the corruption mask constant (bit 0).
REQ-027 The slice SHALL be sub-module util_axis_skid (width-parameterised, packed tdata/tkeep/tlast/tid/tdest payload); injection logic stays in the top module.

Verification
REQ-028 en=0, 100 beats, m_axis_tready=1 -> output identical to input, 1-cycle latency, inject_cnt=0.
REQ-029 en=1, inject_period=4, 16 beats of tdata=0 -> beats 4,8,12,16 have tdata=1, inject_cnt=4.
REQ-030 en=1, inject_period=0, inject_once pulse before beat 3 -> only beat 3 has bit 0 flipped, inject_cnt=1; receiver error asserts.
REQ-031 Random m_axis_tready (50%), 1000 beats -> no loss or duplication, s_axis_tready never low while state!=FULL, full throughput when tready=1.
REQ-032 rst asserted with slice FULL -> next cycle m_axis_tvalid=0, inject_cnt=0, s_axis_tready=0; one cycle after release s_axis_tready=1.
REQ-033 inject_period=1 with inject_once on the same beat -> every beat corrupted, inject_cnt increments by 1 per beat.
